// File: rtl/sample_sequencer.sv
// Sample-playback sequencer: walks a ROM address window, absorbs ROM read latency,
// paces fetches with a period timer and hands each sample downstream over valid/ready.
module sample_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int PERIOD_W = 16,
  parameter int ROM_LAT  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W-1:0]   end_addr,
  input  logic [PERIOD_W-1:0] period,
  input  logic                abort,
  output logic                busy,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [DATA_W-1:0]   rom_data,
  output logic                sample_valid,
  output logic [DATA_W-1:0]   sample_data,
  input  logic                sample_ready,
  output logic                done
);

  typedef enum logic [2:0] {
    IDLE, LOAD, FETCH, PRESENT, WAIT, DONE
  } state_t;

  localparam int              LAT_W    = 4;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ROM_LAT - 1);

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   start_q;
  logic [ADDR_W-1:0]   end_q;
  logic [PERIOD_W-1:0] per_q;
  logic [PERIOD_W-1:0] timer;
  logic [PERIOD_W-1:0] reload;
  logic [LAT_W-1:0]    lat_cnt;

  // period==0 behaves like period==1: back-to-back launches limited only by ROM latency
  assign reload   = (per_q == '0) ? '0 : per_q - PERIOD_W'(1);
  assign rom_addr = ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
      ptr          <= '0;
      sample_data  <= '0;
      timer        <= '0;
      lat_cnt      <= '0;
      start_q      <= '0;
      end_q        <= '0;
      per_q        <= '0;
    end else begin
      done  <= 1'b0;
      timer <= (timer != '0) ? timer - PERIOD_W'(1) : '0;

      if (state != IDLE && abort) begin
        state        <= IDLE;
        busy         <= 1'b0;
        sample_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              start_q <= start_addr;
              end_q   <= end_addr;
              per_q   <= period;
              busy    <= 1'b1;
              state   <= LOAD;
            end
          end
          LOAD: begin
            ptr     <= start_q;
            timer   <= reload;
            lat_cnt <= '0;
            state   <= FETCH;
          end
          FETCH: begin
            if (lat_cnt == LAT_LAST) begin
              sample_data  <= rom_data;
              sample_valid <= 1'b1;
              state        <= PRESENT;
            end else begin
              lat_cnt <= lat_cnt + LAT_W'(1);
            end
          end
          PRESENT: begin
            if (sample_ready) begin
              sample_valid <= 1'b0;
              if (ptr == end_q) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                ptr <= ptr + ADDR_W'(1);
                // timer already expired during the stall: relaunch immediately
                if (timer == '0) begin
                  timer   <= reload;
                  lat_cnt <= '0;
                  state   <= FETCH;
                end else begin
                  state <= WAIT;
                end
              end
            end
          end
          WAIT: begin
            if (timer == '0) begin
              timer   <= reload;
              lat_cnt <= '0;
              state   <= FETCH;
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            state        <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed bench for sample_sequencer: scoreboard of expected (addr, data) per handshake,
// plus cycle-accurate timing, backpressure, abort and reset checks.
module tb_sample_sequencer;
  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int PW  = 16;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          sample_ready = 1'b1;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] end_addr = '0;
  logic [PW-1:0] period = '0;
  logic          busy, sample_valid, done;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data, sample_data;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   hs_cyc[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic          hold_chk = 1'b0;
  logic [DW-1:0] held_data = '0;
  logic [AW-1:0] apipe [LAT-1];

  sample_sequencer #(.ADDR_W(AW), .DATA_W(DW), .PERIOD_W(PW), .ROM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .end_addr(end_addr),
    .period(period), .abort(abort), .busy(busy), .rom_addr(rom_addr), .rom_data(rom_data),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_ready(sample_ready),
    .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rom_val(input logic [AW-1:0] a);
    return (a * 8'd37 + 8'd11) ^ 8'hA5;
  endfunction

  // ROM model: data for an address is visible LAT cycles after the address settles
  always @(posedge clk) begin
    apipe[0] <= rom_addr;
    for (int k = 1; k < LAT - 1; k++) apipe[k] <= apipe[k-1];
  end
  assign rom_data = rom_val(apipe[LAT-2]);

  // Output monitor: handshakes pop the scoreboard, stalled samples must hold steady
  always @(negedge clk) begin
    if (reset) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        tests++;
        assert ({sample_valid, sample_data} === {1'b1, held_data}) else begin
          fails++;
          $error("FAIL stall_hold: observed v=%0b d=%0h expected v=1 d=%0h",
                 sample_valid, sample_data, held_data);
        end
      end
      hold_chk  = sample_valid && !sample_ready;
      held_data = sample_data;
      if (sample_valid && sample_ready) begin
        hs_cyc.push_back(cyc);
        tests++;
        assert (sb.size() != 0) else begin
          fails++;
          $error("FAIL sb_underflow: observed extra sample addr=%0h expected none", rom_addr);
        end
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          tests++;
          assert (rom_addr === e.addr && sample_data === e.data) else begin
            fails++;
            $error("FAIL sample: observed addr=%0h data=%0h expected addr=%0h data=%0h",
                   rom_addr, sample_data, e.addr, e.data);
          end
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic [AW-1:0] sa, input logic [AW-1:0] ea,
                           input logic [PW-1:0] per, input logic ab, output int c0);
    logic [AW-1:0] span;
    exp_t e;
    span = ea - sa;
    for (int i = 0; i <= int'(span); i++) begin
      e.addr = sa + AW'(i);
      e.data = rom_val(e.addr);
      sb.push_back(e);
    end
    hs_cyc.delete();
    start_addr = sa;
    end_addr   = ea;
    period     = per;
    abort      = ab;
    start      = 1'b1;
    c0         = cyc;
    tick();
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output int icyc);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", busy, 0);
    icyc = cyc;
  endtask

  task automatic wait_valid(input int budget, output int vcyc);
    int n = 0;
    while (!sample_valid && n < budget) begin
      tick();
      n++;
    end
    check("valid_timeout", sample_valid, 1);
    vcyc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, ic, vc, dc0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_done", done, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_data", sample_data, 0);
    reset = 1'b0;
    tick();

    // basic run: valids at 6/16/26/36, done at 37, idle at 38
    dc0 = done_cnt;
    start_run(8'h10, 8'h13, 16'd10, 1'b0, c0);
    check("basic_busy_load", busy, 1);
    tick();
    check("basic_rom_addr", rom_addr, 8'h10);
    wait_idle(200, ic);
    check("basic_count", hs_cyc.size(), 4);
    for (int i = 0; i < 4; i++) check("basic_valid_cyc", hs_cyc[i] - c0, 6 + 10 * i);
    check("basic_done_cyc", done_cyc - c0, 37);
    check("basic_done_cnt", done_cnt - dc0, 1);
    check("basic_idle_cyc", ic - c0, 38);
    check("basic_sb_empty", sb.size(), 0);

    // wrap run FE,FF,00,01
    dc0 = done_cnt;
    start_run(8'hFE, 8'h01, 16'd1, 1'b0, c0);
    wait_idle(200, ic);
    check("wrap_count", hs_cyc.size(), 4);
    check("wrap_done_cnt", done_cnt - dc0, 1);
    check("wrap_sb_empty", sb.size(), 0);

    // backpressure: 20-cycle stall on sample 2
    start_run(8'h20, 8'h23, 16'd3, 1'b0, c0);
    wait_valid(50, vc);
    tick();
    sample_ready = 1'b0;
    wait_valid(50, vc);
    repeat (20) tick();
    sample_ready = 1'b1;
    wait_idle(200, ic);
    check("bp_count", hs_cyc.size(), 4);
    check("bp_stall_len", hs_cyc[1] - vc, 20);
    check("bp_relaunch", hs_cyc[2] - hs_cyc[1], 5);
    check("bp_sb_empty", sb.size(), 0);

    // period=0 spacing
    start_run(8'h30, 8'h33, 16'd0, 1'b0, c0);
    wait_idle(200, ic);
    check("p0_count", hs_cyc.size(), 4);
    check("p0_first", hs_cyc[0] - c0, 6);
    for (int i = 1; i < 4; i++) check("p0_spacing", hs_cyc[i] - hs_cyc[i-1], 5);

    // period=1 spacing, with a start issued mid-run that must be ignored
    dc0 = done_cnt;
    start_run(8'h38, 8'h3B, 16'd1, 1'b0, c0);
    repeat (7) tick();
    start_addr = 8'h90;
    end_addr   = 8'h90;
    period     = 16'd20;
    start      = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(200, ic);
    check("p1_count", hs_cyc.size(), 4);
    for (int i = 1; i < 4; i++) check("p1_spacing", hs_cyc[i] - hs_cyc[i-1], 5);
    check("p1_done_cnt", done_cnt - dc0, 1);
    check("p1_sb_empty", sb.size(), 0);

    // abort on 3rd FETCH cycle of sample 2 (FETCH spans cycles 10..13)
    dc0 = done_cnt;
    start_run(8'h40, 8'h47, 16'd8, 1'b0, c0);
    repeat (11) tick();
    check("abort_pre_valid", sample_valid, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", sample_valid, 0);
    repeat (5) tick();
    check("abort_no_done", done_cnt - dc0, 0);
    check("abort_hs_count", hs_cyc.size(), 1);
    sb.delete();

    // reset while presenting a stalled sample
    dc0 = done_cnt;
    sample_ready = 1'b0;
    start_run(8'h50, 8'h52, 16'd1, 1'b0, c0);
    wait_valid(50, vc);
    reset = 1'b1;
    tick();
    check("prst_busy", busy, 0);
    check("prst_valid", sample_valid, 0);
    check("prst_done", done, 0);
    check("prst_rom_addr", rom_addr, 0);
    check("prst_data", sample_data, 0);
    reset = 1'b0;
    sb.delete();
    sample_ready = 1'b1;
    tick();
    check("prst_no_done", done_cnt - dc0, 0);

    // start with abort together in IDLE: start wins, run completes normally
    dc0 = done_cnt;
    start_run(8'h60, 8'h61, 16'd1, 1'b1, c0);
    check("sa_busy", busy, 1);
    wait_idle(200, ic);
    check("sa_count", hs_cyc.size(), 2);
    check("sa_done_cnt", done_cnt - dc0, 1);
    check("sa_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
